instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage between the instruction cache (inside the memory controller) and the decoder.
- Holds the PC and presents it as the fetch address; the memory controller starts a 64-byte line fill whenever the cache misses.
- On a hit, predicts the next PC and pushes {instr, pc, prediction} into an instruction queue that the decoder drains.
- Redirects and flushes on roll_back.

Parameters:
- IQ_DEPTH, 16, instruction queue entries (power of 2).
- BHT_ENTRIES, 256, branch history table entries (power of 2); used only with IF_BHT_EN.

Ports:
- clk  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global pause when low
- roll_back  in  1  misprediction redirect
- rb_pc  in  32  redirect target
- if_ain  out  32  fetch address to the cache
- if_instr_out_en  in  1  cache hit for the current if_ain, same cycle
- if_instr_out  in  32  instruction word for if_ain
- iq_out_valid  out  1  queue head valid
- iq_out_ready  in  1  decoder accepts the head
- iq_out_instr  out  32  head instruction
- iq_out_pc  out  32  head PC
- iq_out_pred_taken  out  1  head predicted taken
- iq_out_pred_pc  out  32  head predicted next PC
- bht_upd_en  in  1  branch resolved
- bht_upd_pc  in  32  resolved branch PC
- bht_upd_taken  in  1  resolved outcome

Behaviour:
- Reset values:
  - pc = 0, so if_ain = 0.
  - Queue empty; head/tail/count = 0.
  - iq_out_valid = 0; iq_out_* data = 0.
- if_ain is driven from the pc register. It holds stable until a push, so a cache miss and fill complete transparently; fetch waits for if_instr_out_en.
- When rdy_in is low, all state is frozen. This includes BHT updates.
- Priority per cycle (rdy_in high): rst_in > roll_back > normal operation.
- roll_back cycle:
  - pc <= rb_pc.
  - Queue cleared (head = tail = count = 0).
  - No push and no pop that cycle.
  - iq_out_valid = 0 the next cycle.
- Push: requires if_instr_out_en && count < IQ_DEPTH.
  - Entry = {if_instr_out, pc, pred_taken, pred_pc}.
  - pc <= pred_pc.
  - Full means count == IQ_DEPTH. Push is blocked when full, even if a pop happens the same cycle.
- Pop: iq_out_valid && iq_out_ready. Head advances, wrapping modulo IQ_DEPTH.
- Simultaneous push and pop when not full: count unchanged.
- Latency: an instruction that hits in cycle N is visible at the queue head in cycle N+1 at the earliest, when the queue was empty.
- Prediction (combinational on if_instr_out; immediates sign-extended to 32 bits, sums wrap modulo 2^32):
  - opcode 1101111 (JAL): taken = 1, pred_pc = pc + J-imm.
  - opcode 1100011 (branch): taken = static rule (below) or BHT; pred_pc = pc + B-imm if taken, else pc + 4.
  - opcode 1100111 (JALR): taken = 0, pred_pc = pc + 4; the backend resolves it via roll_back.
  - Any other opcode: taken = 0, pred_pc = pc + 4.
- Static branch rule (backward-taken, forward-not-taken): taken = B-imm sign bit.
- No internal state machine beyond the FIFO. State = pc register plus queue.

Optional Feature:
- IF_BHT_EN defined:
  - BHT of BHT_ENTRIES 2-bit saturating counters, indexed by pc[log2(BHT_ENTRIES)+1:2]. All counters reset to 01.
  - Branch prediction: taken = counter[1].
  - On bht_upd_en, the counter at bht_upd_pc increments when bht_upd_taken = 1, otherwise decrements, saturating at 00 and 11.
  - Updates happen even in a roll_back cycle.
  - A same-cycle update and lookup of the same entry reads the old value.
- IF_BHT_EN undefined: static rule only. bht_upd_* ports exist but are ignored; no BHT storage.

Decomposition:
- Shared include/package:
  - Opcode constants (JAL, JALR, BRANCH).
  - ADDR_WIDTH / INSTR_WIDTH.
  - IQ entry field layout.
  - Immediate-extraction functions for J-type and B-type.
- Natural sub-module: instr_queue, a parameterised synchronous FIFO with flush, push/pop, full/empty, and registered head outputs.
- Prediction logic and BHT stay in instr_fetch.

Test Plan:
- Reset; cache hits addi (0x00100093) at 0 with ready = 1 → head {instr 0x00100093, pc 0, taken 0, pred_pc 4}; if_ain = 4.
- if_instr_out_en held low 70 cycles at pc 0x40 → if_ain stays 0x40, no push; on hit, the entry carries pc 0x40.
- JAL +0x20 at 0x10 → pred_taken 1, pred_pc 0x30; next if_ain 0x30. BEQ imm −8 at 0x40 → taken, 0x38. BEQ imm +8 at 0x40 → not taken, 0x44.
- iq_out_ready = 0, continuous hits → exactly 16 pushes, no further push, if_ain frozen; one pop with a concurrent hit → no push that cycle, push on the next.
- Queue holds 5 entries, roll_back with rb_pc 0x100 → next cycle iq_out_valid 0, if_ain 0x100; a hit that cycle is not enqueued.
- IF_BHT_EN: forward BEQ at 0x80, two updates taken = 1 → predicted taken, pred_pc = 0x80 + imm; rdy_in low during an update → counter unchanged.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, opcodes, queue entry layout
// and the J/B immediate decoders used by next-PC prediction.
package instr_fetch_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   pred_taken;
        logic [ADDR_WIDTH-1:0]  pred_pc;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    function automatic logic [ADDR_WIDTH-1:0] imm_j(input logic [INSTR_WIDTH-1:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] imm_b(input logic [INSTR_WIDTH-1:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// instr_queue: synchronous FIFO with flush, frozen when en_i is low.
// The head entry is kept in registers so outputs never come straight off the array.
module instr_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o       = (count_q == CNT_W'(DEPTH));
        do_push      = push_i && !full_o && !flush_i;
        do_pop       = pop_i && head_valid_q && !flush_i;
        head_d       = head_q + PTR_W'(do_pop);
        tail_d       = tail_q + PTR_W'(do_push);
        count_d      = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_valid_d = (count_d != '0);
        head_data_d  = '0;
        if (flush_i) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else if (count_d != '0) begin
            // A push into an otherwise-empty queue bypasses the array into the head.
            if (do_push && (tail_q == head_d))
                head_data_d = push_data_i;
            else
                head_data_d = mem_q[head_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else if (en_i) begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in && en_i && do_push)
            mem_q[tail_q] <= push_data_i;
    end

    assign head_valid_o = head_valid_q;
    assign head_data_o  = head_data_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC prediction and the instruction queue.
// Define IF_BHT_EN to predict conditional branches with a 2-bit counter table.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IQ_DEPTH    = 16,
    parameter int BHT_ENTRIES = 256
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] rb_pc,
    output logic [31:0] if_ain,
    input  logic        if_instr_out_en,
    input  logic [31:0] if_instr_out,
    output logic        iq_out_valid,
    input  logic        iq_out_ready,
    output logic [31:0] iq_out_instr,
    output logic [31:0] iq_out_pc,
    output logic        iq_out_pred_taken,
    output logic [31:0] iq_out_pred_pc,
    input  logic        bht_upd_en,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pred_pc, b_imm;
    logic                  pred_taken, branch_taken, iq_full, push_ok;
    logic [BHT_IDX_W-1:0]  bht_upd_idx;
    iq_entry_t             push_entry, head_entry;

    assign bht_upd_idx = bht_upd_pc[BHT_IDX_W+1:2];
    assign b_imm       = imm_b(if_instr_out);
    wire unused_upd_pc = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

`ifdef IF_BHT_EN
    logic [1:0] bht_q [BHT_ENTRIES];

    // Lookup reads the pre-update counter when both hit the same entry.
    assign branch_taken = bht_q[pc_q[BHT_IDX_W+1:2]][1];

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (rdy_in && bht_upd_en) begin
            if (bht_upd_taken && (bht_q[bht_upd_idx] != 2'b11))
                bht_q[bht_upd_idx] <= bht_q[bht_upd_idx] + 2'd1;
            else if (!bht_upd_taken && (bht_q[bht_upd_idx] != 2'b00))
                bht_q[bht_upd_idx] <= bht_q[bht_upd_idx] - 2'd1;
        end
    end
`else
    // Backward branches taken, forward branches not taken.
    assign branch_taken = b_imm[31];
    wire unused_bht_off = ^{bht_upd_en, bht_upd_taken, bht_upd_idx};
`endif

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_q + 32'd4;
        case (if_instr_out[6:0])
            OPC_JAL: begin
                pred_taken = 1'b1;
                pred_pc    = pc_q + imm_j(if_instr_out);
            end
            OPC_BRANCH: begin
                pred_taken = branch_taken;
                if (branch_taken) pred_pc = pc_q + b_imm;
            end
            OPC_JALR: begin
                pred_taken = 1'b0;
            end
            default: begin
                pred_taken = 1'b0;
            end
        endcase
    end

    assign push_ok    = if_instr_out_en && !iq_full && !roll_back;
    assign push_entry = '{instr: if_instr_out, pc: pc_q, pred_taken: pred_taken, pred_pc: pred_pc};

    always_comb begin
        pc_d = pc_q;
        if (roll_back)    pc_d = rb_pc;
        else if (push_ok) pc_d = pred_pc;
    end

    always_ff @(posedge clk) begin
        if (rst_in)      pc_q <= '0;
        else if (rdy_in) pc_q <= pc_d;
    end

    logic [IQ_ENTRY_W-1:0] head_bits;

    instr_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_ENTRY_W)
    ) u_iq (
        .clk          (clk),
        .rst_in       (rst_in),
        .en_i         (rdy_in),
        .flush_i      (roll_back),
        .push_i       (if_instr_out_en),
        .push_data_i  (push_entry),
        .pop_i        (iq_out_ready),
        .full_o       (iq_full),
        .head_valid_o (iq_out_valid),
        .head_data_o  (head_bits)
    );

    assign head_entry        = iq_entry_t'(head_bits);
    assign if_ain            = pc_q;
    assign iq_out_instr      = head_entry.instr;
    assign iq_out_pc         = head_entry.pc;
    assign iq_out_pred_taken = head_entry.pred_taken;
    assign iq_out_pred_pc    = head_entry.pred_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a
// queue-based reference model; outputs compared every cycle on the falling edge.
module tb_instr_fetch;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, roll_back = 1'b0;
    logic [31:0] rb_pc = '0;
    logic        if_instr_out_en = 1'b0;
    logic [31:0] if_instr_out = '0;
    logic        iq_out_ready = 1'b0;
    logic        bht_upd_en = 1'b0, bht_upd_taken = 1'b0;
    logic [31:0] bht_upd_pc = '0;
    wire  [31:0] if_ain, iq_out_instr, iq_out_pc, iq_out_pred_pc;
    wire         iq_out_valid, iq_out_pred_taken;

    instr_fetch dut (
        .clk               (clk),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .roll_back         (roll_back),
        .rb_pc             (rb_pc),
        .if_ain            (if_ain),
        .if_instr_out_en   (if_instr_out_en),
        .if_instr_out      (if_instr_out),
        .iq_out_valid      (iq_out_valid),
        .iq_out_ready      (iq_out_ready),
        .iq_out_instr      (iq_out_instr),
        .iq_out_pc         (iq_out_pc),
        .iq_out_pred_taken (iq_out_pred_taken),
        .iq_out_pred_pc    (iq_out_pred_pc),
        .bht_upd_en        (bht_upd_en),
        .bht_upd_pc        (bht_upd_pc),
        .bht_upd_taken     (bht_upd_taken)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int           n_cmp = 0, n_fail = 0;
    logic         chk_en = 1'b0;
    logic [31:0]  m_pc = '0;
    logic [96:0]  exp_q[$];   // {instr, pc, taken, pred_pc}
    logic [1:0]   m_bht[256];
    logic [96:0]  cmp_h;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic predict(input logic [31:0] pc, input logic [31:0] ins,
                           output logic taken, output logic [31:0] npc);
        logic [31:0] jimm, bimm;
        logic        btaken;
        jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
`ifdef IF_BHT_EN
        btaken = m_bht[pc[9:2]][1];
`else
        btaken = bimm[31];
`endif
        taken = 1'b0;
        npc   = pc + 32'd4;
        if (ins[6:0] == 7'b1101111) begin
            taken = 1'b1;
            npc   = pc + jimm;
        end else if (ins[6:0] == 7'b1100011 && btaken) begin
            taken = 1'b1;
            npc   = pc + bimm;
        end
    endtask

    task automatic m_step();
        logic        t;
        logic [31:0] npc;
        logic        do_push, do_pop;
        if (rst_in) begin
            m_pc = '0;
            exp_q.delete();
            foreach (m_bht[i]) m_bht[i] = 2'b01;
        end else if (rdy_in) begin
            predict(m_pc, if_instr_out, t, npc);
            if (roll_back) begin
                m_pc = rb_pc;
                exp_q.delete();
            end else begin
                do_pop  = (exp_q.size() != 0) && iq_out_ready;
                do_push = if_instr_out_en && (exp_q.size() < DEPTH);
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    exp_q.push_back({if_instr_out, m_pc, t, npc});
                    m_pc = npc;
                end
            end
`ifdef IF_BHT_EN
            if (bht_upd_en) begin
                if (bht_upd_taken && m_bht[bht_upd_pc[9:2]] != 2'b11)
                    m_bht[bht_upd_pc[9:2]] = m_bht[bht_upd_pc[9:2]] + 2'd1;
                else if (!bht_upd_taken && m_bht[bht_upd_pc[9:2]] != 2'b00)
                    m_bht[bht_upd_pc[9:2]] = m_bht[bht_upd_pc[9:2]] - 2'd1;
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_ain", if_ain, m_pc);
            chk("iq_out_valid", {31'b0, iq_out_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                cmp_h = exp_q[0];
                chk("iq_out_instr", iq_out_instr, cmp_h[96:65]);
                chk("iq_out_pc", iq_out_pc, cmp_h[64:33]);
                chk("iq_out_pred_taken", {31'b0, iq_out_pred_taken}, {31'b0, cmp_h[32]});
                chk("iq_out_pred_pc", iq_out_pred_pc, cmp_h[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic hit(input logic [31:0] ins);
        if_instr_out_en = 1'b1;
        if_instr_out    = ins;
        tick();
        if_instr_out_en = 1'b0;
    endtask

    task automatic rb_to(input logic [31:0] addr);
        roll_back       = 1'b1;
        rb_pc           = addr;
        if_instr_out_en = 1'b0;
        tick();
        roll_back = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 5))
            0:       return 32'h0010_0093;
            1:       return ($urandom & 32'hFFFF_FF80) | 32'h6F;
            2:       return ($urandom & 32'hFFFF_FF80) | 32'h63;
            3:       return ($urandom & 32'hFFFF_FF80) | 32'h67;
            4:       return 32'hFE00_0CE3;
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] ADDI    = 32'h0010_0093;
    localparam logic [31:0] JAL_P32 = 32'h0200_006F;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P8  = 32'h0000_0463;

    initial begin
        // reset
        rst_in = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("reset if_ain", if_ain, 32'h0);
        chk("reset valid", {31'b0, iq_out_valid}, 32'h0);
        chk("reset instr", iq_out_instr, 32'h0);
        chk("reset pc", iq_out_pc, 32'h0);
        chk("reset pred_pc", iq_out_pred_pc, 32'h0);
        chk("reset taken", {31'b0, iq_out_pred_taken}, 32'h0);

        // first hit: addi at 0
        hit(ADDI);
        chk("addi valid", {31'b0, iq_out_valid}, 32'h1);
        chk("addi instr", iq_out_instr, ADDI);
        chk("addi pc", iq_out_pc, 32'h0);
        chk("addi taken", {31'b0, iq_out_pred_taken}, 32'h0);
        chk("addi pred_pc", iq_out_pred_pc, 32'h4);
        chk("addi if_ain", if_ain, 32'h4);

        // long miss at 0x40
        rb_to(32'h40);
        repeat (70) tick();
        chk("miss if_ain", if_ain, 32'h40);
        chk("miss valid", {31'b0, iq_out_valid}, 32'h0);
        hit(ADDI);
        chk("fill pc", iq_out_pc, 32'h40);
        chk("fill if_ain", if_ain, 32'h44);

        // JAL and branches
        rb_to(32'h10);
        hit(JAL_P32);
        chk("jal taken", {31'b0, iq_out_pred_taken}, 32'h1);
        chk("jal pred_pc", iq_out_pred_pc, 32'h30);
        chk("jal if_ain", if_ain, 32'h30);
        rb_to(32'h40);
        hit(BEQ_M8);
`ifdef IF_BHT_EN
        chk("beq-8 taken", {31'b0, iq_out_pred_taken}, 32'h0);
        chk("beq-8 pred_pc", iq_out_pred_pc, 32'h44);
`else
        chk("beq-8 taken", {31'b0, iq_out_pred_taken}, 32'h1);
        chk("beq-8 pred_pc", iq_out_pred_pc, 32'h38);
`endif
        rb_to(32'h40);
        hit(BEQ_P8);
        chk("beq+8 taken", {31'b0, iq_out_pred_taken}, 32'h0);
        chk("beq+8 pred_pc", iq_out_pred_pc, 32'h44);

        // fill to capacity
        rb_to(32'h0);
        iq_out_ready = 1'b0;
        if_instr_out_en = 1'b1;
        if_instr_out = ADDI;
        repeat (20) tick();
        chk("full if_ain", if_ain, 32'h40);
        iq_out_ready = 1'b1;
        tick();
        chk("full pop no push", if_ain, 32'h40);
        chk("full pop head", iq_out_pc, 32'h4);
        iq_out_ready = 1'b0;
        tick();
        chk("full push after pop", if_ain, 32'h44);
        if_instr_out_en = 1'b0;

        // roll_back with 5 entries
        rb_to(32'h0);
        if_instr_out_en = 1'b1;
        repeat (5) tick();
        roll_back = 1'b1;
        rb_pc = 32'h100;
        tick();
        roll_back = 1'b0;
        if_instr_out_en = 1'b0;
        chk("rb valid", {31'b0, iq_out_valid}, 32'h0);
        chk("rb if_ain", if_ain, 32'h100);
        tick();
        chk("rb no enqueue", {31'b0, iq_out_valid}, 32'h0);

        // counter training, then updates while paused must not count
        rb_to(32'h80);
        bht_upd_en = 1'b1;
        bht_upd_pc = 32'h80;
        bht_upd_taken = 1'b1;
        repeat (2) tick();
        bht_upd_taken = 1'b0;
        rdy_in = 1'b0;
        if_instr_out_en = 1'b1;
        if_instr_out = ADDI;
        repeat (2) tick();
        chk("pause if_ain", if_ain, 32'h80);
        chk("pause valid", {31'b0, iq_out_valid}, 32'h0);
        rdy_in = 1'b1;
        bht_upd_en = 1'b0;
        hit(BEQ_P8);
`ifdef IF_BHT_EN
        chk("bht taken", {31'b0, iq_out_pred_taken}, 32'h1);
        chk("bht pred_pc", iq_out_pred_pc, 32'h88);
`else
        chk("bht taken", {31'b0, iq_out_pred_taken}, 32'h0);
        chk("bht pred_pc", iq_out_pred_pc, 32'h84);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_in          = ($urandom_range(0, 299) == 0);
            rdy_in          = ($urandom_range(0, 9) != 0);
            roll_back       = ($urandom_range(0, 19) == 0);
            rb_pc           = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 2);
            if_instr_out_en = ($urandom_range(0, 9) < 6);
            if_instr_out    = rand_instr();
            iq_out_ready    = ($urandom_range(0, 1) == 1);
            bht_upd_en      = ($urandom_range(0, 2) == 0);
            bht_upd_pc      = ($urandom_range(0, 1) == 1) ? m_pc : (32'($urandom_range(0, 63)) << 2);
            bht_upd_taken   = ($urandom_range(0, 1) == 1);
            tick();
        end

        rst_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
